// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg
// Shared definitions for the GPIO bank array: register offsets within a bank,
// the interrupt-type encoding and an address-width helper.
// No ports (package).

package gpio_bank_pkg;

    // Register offsets within one bank (paddr[2:0]).
    typedef enum logic [2:0] {
        REG_DIR   = 3'd0,
        REG_OUT   = 3'd1,
        REG_PU    = 3'd2,
        REG_PD    = 3'd3,
        REG_IN    = 3'd4,
        REG_IEN   = 3'd5,
        REG_ITYPE = 3'd6,
        REG_ISTAT = 3'd7
    } reg_off_e;

    // Per-pin interrupt type held in ITYPE.
    typedef enum logic {
        ITYPE_RISE = 1'b0,
        ITYPE_FALL = 1'b1
    } itype_e;

    // Smallest paddr width able to address every bank: 3 offset bits plus the
    // bank index bits.
    function automatic int min_addr_width(input int bank_num);
        return 3 + $clog2(bank_num);
    endfunction

endpackage

// File: rtl/gpio_bank_regs.sv
// gpio_bank_regs
// One GPIO bank: eight registers, per-pin input synchroniser, edge detection,
// sticky W1C interrupt status and a registered bank interrupt.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   sel            this bank is addressed
//   wr             APB write commit strobe (access phase of a write)
//   off            register offset
//   wdata          write data
//   y              raw pad inputs (asynchronous)
//   rdata          combinational read value of the addressed register
//   oe, a, pu, pd  pad controls
//   irq_bank       registered |(ISTAT & IEN)

module gpio_bank_regs
    import gpio_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sel,
    input  logic                  wr,
    input  logic [2:0]            off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] y,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] oe,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] pu,
    output logic [DATA_WIDTH-1:0] pd,
    output logic                  irq_bank
);

    logic [DATA_WIDTH-1:0] dir_r, out_r, pu_r, pd_r, ien_r, itype_r, istat_r;
    logic [DATA_WIDTH-1:0] sync1_r, sync2_r, prev_r, pd_drv_r;
    logic                  irq_r;

    logic [DATA_WIDTH-1:0] dir_nxt_s, out_nxt_s, pu_nxt_s, pd_nxt_s;
    logic [DATA_WIDTH-1:0] ien_nxt_s, itype_nxt_s, clr_s, edge_s, istat_nxt_s;
    reg_off_e              off_s;

    assign off_s = reg_off_e'(off);

    // Write decode: next values of the RW registers and the ISTAT clear mask.
    always_comb begin
        dir_nxt_s   = dir_r;
        out_nxt_s   = out_r;
        pu_nxt_s    = pu_r;
        pd_nxt_s    = pd_r;
        ien_nxt_s   = ien_r;
        itype_nxt_s = itype_r;
        clr_s       = '0;
        if (sel && wr) begin
            case (off_s)
                REG_DIR:   dir_nxt_s   = wdata;
                REG_OUT:   out_nxt_s   = wdata;
                REG_PU:    pu_nxt_s    = wdata;
                REG_PD:    pd_nxt_s    = wdata;
                REG_IN:    clr_s       = '0;   // read-only, write silently dropped
                REG_IEN:   ien_nxt_s   = wdata;
                REG_ITYPE: itype_nxt_s = wdata;
                REG_ISTAT: clr_s       = wdata;
                default:   clr_s       = '0;
            endcase
        end else begin
            clr_s = '0;
        end
    end

    // Edge detect on synchronised input vs. its previous sample; a new edge
    // overrides a same-cycle W1C clear.
    always_comb begin
        edge_s = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (itype_e'(itype_r[i]) == ITYPE_FALL) begin
                edge_s[i] = ~sync2_r[i] & prev_r[i];
            end else begin
                edge_s[i] = sync2_r[i] & ~prev_r[i];
            end
        end
        istat_nxt_s = (istat_r & ~clr_s) | edge_s;
    end

    // Read mux for the addressed register.
    always_comb begin
        rdata = '0;
        case (off_s)
            REG_DIR:   rdata = dir_r;
            REG_OUT:   rdata = out_r;
            REG_PU:    rdata = pu_r;
            REG_PD:    rdata = pd_r;
            REG_IN:    rdata = sync2_r;
            REG_IEN:   rdata = ien_r;
            REG_ITYPE: rdata = itype_r;
            REG_ISTAT: rdata = istat_r;
            default:   rdata = '0;
        endcase
    end

    // Configuration registers; pd drive is masked by pu so pull-up wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_r    <= '0;
            out_r    <= '0;
            pu_r     <= '0;
            pd_r     <= '0;
            ien_r    <= '0;
            itype_r  <= '0;
            pd_drv_r <= '0;
        end else begin
            dir_r    <= dir_nxt_s;
            out_r    <= out_nxt_s;
            pu_r     <= pu_nxt_s;
            pd_r     <= pd_nxt_s;
            ien_r    <= ien_nxt_s;
            itype_r  <= itype_nxt_s;
            pd_drv_r <= pd_nxt_s & ~pu_nxt_s;
        end
    end

    // Two-flop synchroniser plus the previous-sample flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
            prev_r  <= '0;
        end else begin
            sync1_r <= y;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Sticky interrupt status and the bank interrupt one edge behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            istat_r <= '0;
            irq_r   <= 1'b0;
        end else begin
            istat_r <= istat_nxt_s;
            irq_r   <= |(istat_r & ien_r);
        end
    end

    assign oe       = dir_r;
    assign a        = out_r;
    assign pu       = pu_r;
    assign pd       = pd_drv_r;
    assign irq_bank = irq_r;

endmodule

// File: rtl/gpio_bank_array.sv
// gpio_bank_array
// APB slave serving BANK_NUM identical 8-register GPIO banks.
// Ports:
//   pclk, preset          clock, asynchronous active-high reset
//   psel, penable, pwrite APB control
//   paddr                 [2:0] register offset, upper bits bank index
//   pwdata / prdata       APB data (prdata registered at the setup edge)
//   pready, pslverr       zero-wait-state completion, out-of-range bank error
//   y                     pad inputs (asynchronous)
//   oe, a, pu, pd         pad controls, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
//   irq_bank, irq         per-bank interrupts and their OR
// The package helper min_addr_width() gives the smallest legal ADDR_WIDTH.

module gpio_bank_array
    import gpio_bank_pkg::*;
#(
    parameter int BANK_NUM   = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [BANK_NUM*DATA_WIDTH-1:0] y,
    output logic [BANK_NUM*DATA_WIDTH-1:0] oe,
    output logic [BANK_NUM*DATA_WIDTH-1:0] a,
    output logic [BANK_NUM*DATA_WIDTH-1:0] pu,
    output logic [BANK_NUM*DATA_WIDTH-1:0] pd,
    output logic [BANK_NUM-1:0]            irq_bank,
    output logic                           irq
);

    localparam int IDX_W = ADDR_WIDTH - 3;

    logic [IDX_W-1:0]      bank_idx_s;
    logic [2:0]            off_s;
    logic                  bank_ok_s, setup_s, setup_rd_s, wr_s;
    logic [BANK_NUM-1:0]   bank_sel_s;
    logic [DATA_WIDTH-1:0] bank_rdata_s [BANK_NUM];
    logic [DATA_WIDTH-1:0] rd_mux_s, prdata_r;
    logic                  pslverr_r;

    assign bank_idx_s = paddr[ADDR_WIDTH-1:3];
    assign off_s      = paddr[2:0];

    // Bank decode, APB phase strobes and read mux.
    always_comb begin
        bank_ok_s  = (32'(bank_idx_s) < 32'(BANK_NUM));
        setup_s    = psel & ~penable;
        setup_rd_s = setup_s & ~pwrite;
        wr_s       = psel & penable & pwrite;
        bank_sel_s = '0;
        rd_mux_s   = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            bank_sel_s[b] = (bank_idx_s == IDX_W'(b));
            rd_mux_s      = rd_mux_s | (bank_sel_s[b] ? bank_rdata_s[b] : '0);
        end
    end

    // Read data and error captured at the setup edge; both fall back to 0 on
    // any other edge so they are only non-zero during the access phase.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
        end else begin
            prdata_r  <= (setup_rd_s && bank_ok_s) ? rd_mux_s : '0;
            pslverr_r <= setup_s & ~bank_ok_s;
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        gpio_bank_regs #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk      (pclk),
            .rst      (preset),
            .sel      (bank_sel_s[b]),
            .wr       (wr_s),
            .off      (off_s),
            .wdata    (pwdata),
            .y        (y[b*DATA_WIDTH +: DATA_WIDTH]),
            .rdata    (bank_rdata_s[b]),
            .oe       (oe[b*DATA_WIDTH +: DATA_WIDTH]),
            .a        (a[b*DATA_WIDTH +: DATA_WIDTH]),
            .pu       (pu[b*DATA_WIDTH +: DATA_WIDTH]),
            .pd       (pd[b*DATA_WIDTH +: DATA_WIDTH]),
            .irq_bank (irq_bank[b])
        );
    end

    assign prdata  = prdata_r;
    assign pslverr = pslverr_r;
    assign pready  = psel & penable;
    assign irq     = |irq_bank;

endmodule

// File: tb/tb_gpio_bank_array.sv
// Self-checking bench for gpio_bank_array: directed scenarios with literal
// expectations, then randomized APB traffic and pad activity, all checked every
// cycle against a register-array / pad-history model.

module tb_gpio_bank_array;

    localparam int BN = 2;
    localparam int DW = 8;
    localparam int AW = 7;
    localparam int W  = BN * DW;

    logic          pclk = 1'b0;
    logic          preset, psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;
    logic [W-1:0]  y, oe, a, pu, pd;
    logic [BN-1:0] irq_bank;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    gpio_bank_array #(
        .BANK_NUM   (BN),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .y        (y),
        .oe       (oe),
        .a        (a),
        .pu       (pu),
        .pd       (pd),
        .irq_bank (irq_bank),
        .irq      (irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_reg[bank][offset] holds what software wrote (IN slot unused);
    // y_hist[k] is the pad value seen k+1 clock edges ago.
    logic [DW-1:0] m_reg [BN][8];
    logic [W-1:0]  y_hist [3];
    logic [BN-1:0] m_irqb;
    logic [DW-1:0] m_prd;
    logic          m_err;

    function automatic logic [W-1:0] flat(input int r);
        logic [W-1:0] v;
        for (int b = 0; b < BN; b++) v[b*DW +: DW] = m_reg[b][r];
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BN; b++)
            for (int r = 0; r < 8; r++) m_reg[b][r] = '0;
        for (int k = 0; k < 3; k++) y_hist[k] = '0;
        m_irqb = '0;
        m_prd  = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge();
        int            bk, off;
        logic          ok;
        logic [DW-1:0] setv [BN];
        logic [BN-1:0] irqn;
        logic          now_v, old_v;
        bk  = int'(paddr[AW-1:3]);
        off = int'(paddr[2:0]);
        ok  = (bk < BN);
        for (int b = 0; b < BN; b++) begin
            irqn[b] = |(m_reg[b][7] & m_reg[b][5]);
            for (int i = 0; i < DW; i++) begin
                // pad value 2 edges ago vs 3 edges ago
                now_v = y_hist[1][b*DW + i];
                old_v = y_hist[2][b*DW + i];
                setv[b][i] = m_reg[b][6][i] ? (old_v && !now_v) : (!old_v && now_v);
            end
        end
        if (psel && !penable && !pwrite && ok)
            m_prd = (off == 4) ? y_hist[1][bk*DW +: DW] : m_reg[bk][off];
        else
            m_prd = '0;
        m_err = psel && !penable && !ok;
        if (psel && penable && pwrite && ok) begin
            if (off == 7)      m_reg[bk][7] = m_reg[bk][7] & ~pwdata;
            else if (off != 4) m_reg[bk][off] = pwdata;
        end
        for (int b = 0; b < BN; b++) m_reg[b][7] = m_reg[b][7] | setv[b];
        m_irqb    = irqn;
        y_hist[2] = y_hist[1];
        y_hist[1] = y_hist[0];
        y_hist[0] = y;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge pclk or posedge preset);
            if (preset) model_reset();
            else        model_edge();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge pclk);
            chk("oe",       oe,       flat(0));
            chk("a",        a,        flat(1));
            chk("pu",       pu,       flat(2));
            chk("pd",       pd,       flat(3) & ~flat(2));
            chk("prdata",   prdata,   m_prd);
            chk("pslverr",  pslverr,  m_err);
            chk("pready",   pready,   psel && penable);
            chk("irq_bank", irq_bank, m_irqb);
            chk("irq",      irq,      |m_irqb);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    // Setup then access phase; returns with the access phase being driven.
    task automatic xfer(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd, output logic er);
        step();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = ad; pwdata = wd;
        step();
        penable = 1'b1;
        rd = prdata;
        er = pslverr;
    endtask

    task automatic idle();
        step();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr_reg(input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        logic [DW-1:0] rd;
        logic          er;
        xfer(1'b1, ad, wd, rd, er);
        idle();
    endtask

    task automatic rd_reg(input logic [AW-1:0] ad, output logic [DW-1:0] rd, output logic er);
        xfer(1'b0, ad, 8'h00, rd, er);
        idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] rd;
        logic          er;
        logic [AW-1:0] ad;
        int            bk;

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; y = '0;
        repeat (3) step();
        chk("reset_oe", oe, 16'h0000);
        chk("reset_irq", irq, 1'b0);
        preset = 1'b0;
        step();
        chk("reset_prdata", prdata, 8'h00);

        // DIR/OUT of bank 1
        wr_reg(7'h08, 8'hA5);
        chk("dir_b1_oe", oe[15:8], 8'hA5);
        wr_reg(7'h09, 8'h3C);
        chk("out_b1_a", a[15:8], 8'h3C);
        rd_reg(7'h08, rd, er);
        chk("rd_dir_b1", rd, 8'hA5);
        chk("rd_dir_b1_err", er, 1'b0);
        rd_reg(7'h09, rd, er);
        chk("rd_out_b1", rd, 8'h3C);

        // PU/PD conflict on bank 0
        wr_reg(7'h02, 8'hFF);
        wr_reg(7'h03, 8'h0F);
        chk("pd_conflict", pd[7:0], 8'h00);
        chk("pu_b0", pu[7:0], 8'hFF);
        rd_reg(7'h03, rd, er);
        chk("rd_pd_b0", rd, 8'h0F);

        // Rising edge on y[3], IEN bit 3
        wr_reg(7'h06, 8'h00);
        wr_reg(7'h05, 8'h08);
        wr_reg(7'h07, 8'hFF);
        y[3] = 1'b1;
        repeat (3) step();
        chk("irq_before_lag", irq, 1'b0);
        step();
        chk("irq_rise", irq, 1'b1);
        chk("irq_bank_rise", irq_bank, 2'b01);
        rd_reg(7'h04, rd, er);
        chk("rd_in_b0", rd, 8'h08);
        rd_reg(7'h07, rd, er);
        chk("rd_istat_b0", rd, 8'h08);
        xfer(1'b1, 7'h07, 8'h08, rd, er);
        idle();
        chk("irq_after_clr_lag", irq, 1'b1);
        step();
        chk("irq_cleared", irq, 1'b0);

        // Falling edge on y[9], IEN = 0 on bank 1
        y[9] = 1'b1;
        repeat (4) step();
        wr_reg(7'h0E, 8'h02);
        wr_reg(7'h0D, 8'h00);
        wr_reg(7'h0F, 8'hFF);
        y[9] = 1'b0;
        repeat (4) step();
        rd_reg(7'h0F, rd, er);
        chk("rd_istat_fall", rd, 8'h02);
        chk("irq_ien0", irq, 1'b0);
        y[9] = 1'b1;
        repeat (4) step();
        wr_reg(7'h0F, 8'h02);
        rd_reg(7'h0F, rd, er);
        chk("rd_istat_w1c", rd, 8'h00);
        y[9] = 1'b0;
        xfer(1'b1, 7'h0F, 8'h02, rd, er);   // commits on the edge the fall is detected
        idle();
        rd_reg(7'h0F, rd, er);
        chk("w1c_vs_set", rd, 8'h02);

        // Out-of-range bank
        xfer(1'b1, 7'h10, 8'hFF, rd, er);
        chk("oor_wr_err", er, 1'b1);
        idle();
        chk("oor_wr_ignored", oe, 16'hA500);
        xfer(1'b0, 7'h10, 8'h00, rd, er);
        chk("oor_rd_data", rd, 8'h00);
        chk("oor_rd_err", er, 1'b1);
        idle();
        chk("err_clears", pslverr, 1'b0);

        // Reset in the middle of a write access
        step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 7'h00; pwdata = 8'h55;
        step();
        penable = 1'b1;
        #2 preset = 1'b1;
        #1;
        chk("abort_oe", oe, 16'h0000);
        chk("abort_a", a, 16'h0000);
        chk("abort_pu", pu, 16'h0000);
        chk("abort_irq", {irq_bank, irq, pslverr, prdata}, 64'h0);
        step();
        psel = 1'b0; penable = 1'b0; preset = 1'b0;
        y = '0;
        repeat (4) step();
        wr_reg(7'h00, 8'h66);
        chk("post_abort_wr", oe, 16'h0066);

        // Randomized traffic, some back-to-back, some out-of-range
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) y[$urandom_range(0, W-1)] ^= 1'b1;
            if ($urandom_range(0, 5) == 0) bk = $urandom_range(2, 15);
            else                           bk = $urandom_range(0, BN-1);
            ad = {bk[3:0], 3'($urandom_range(0, 7))};
            xfer(1'($urandom_range(0, 1)), ad, 8'($urandom), rd, er);
            if ($urandom_range(0, 2) != 0) idle();
        end
        idle();
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_bank_array.md
Name: gpio_bank_array

Overview:
- Parametrised successor to the fixed two-bank expander core: an APB slave serving BANK_NUM identical 8-register GPIO banks.
- Adds per-pin input synchronisation, edge-detect interrupts with sticky W1C status, bank-range error reporting and a registered read path.
- Sits between the SPI-to-APB bridge and the gpio_pad array.
- Replaces the hand-written bank decode/mux with a generate loop.

Parameters:
- BANK_NUM, 2: number of GPIO banks; 1..16.
- DATA_WIDTH, 8: pins per bank; also the APB data width.
- ADDR_WIDTH, 7: paddr width; must be >= 3 + clog2(BANK_NUM).

Ports:
- pclk  in  1  APB clock; sole clock.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write.
- paddr  in  ADDR_WIDTH  [2:0] register offset; [ADDR_WIDTH-1:3] bank index.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data, valid in the access phase.
- pready  out  1  transfer complete.
- pslverr  out  1  error response.
- y  in  BANK_NUM*DATA_WIDTH  pad input values, asynchronous to pclk.
- oe, a, pu, pd  out  BANK_NUM*DATA_WIDTH each  pad controls; bank b drives bits [b*DATA_WIDTH +: DATA_WIDTH].
- irq_bank  out  BANK_NUM  per-bank interrupt.
- irq  out  1  OR of irq_bank.

Behaviour:
- Reset: one clock (pclk); reset is asynchronous and active-high (preset). On preset, all registers, synchronisers, prdata, pslverr and irq/irq_bank clear to 0 immediately. oe = 0 (all pins inputs).
- Register offsets within each bank:
  - 0 DIR (RW, drives oe)
  - 1 OUT (RW, drives a)
  - 2 PU (RW)
  - 3 PD (RW)
  - 4 IN (RO, synchronised y)
  - 5 IEN (RW)
  - 6 ITYPE (RW; 0 = rising, 1 = falling)
  - 7 ISTAT (RW1C, sticky)
- APB protocol: zero wait states; pready = psel & penable.
  - Write: commits on the pclk edge where psel & penable & pwrite.
  - Read: prdata is registered at the setup edge (psel & !penable & !pwrite) and held through the access phase. It returns 0 outside read transfers.
- Bank index >= BANK_NUM:
  - pslverr = 1 in the access phase (registered at setup).
  - Writes are ignored; reads return 0.
  - pslverr is otherwise 0.
- Writes to IN are ignored and raise no error.
- PU/PD conflict: pd output = PD & ~PU, so pull-up wins. Register contents stay as written and read back unchanged.
- Input path: y passes through a 2-flop synchroniser per pin. IN reflects the second flop, i.e. a pad change is visible on IN 2 edges later.
- Edge detect: compares the second flop with a third (prev) flop.
  - Rising: sync & ~prev. Falling: ~sync & prev.
  - The ISTAT bit sets on the edge after detection regardless of IEN. Total pad-to-ISTAT latency is 3 edges.
  - Rising mode fires when y rises; falling mode fires when y falls.
- ISTAT clear: writing 1 to a bit clears it; writing 0 leaves it unchanged. If a set and a clear hit the same bit in the same cycle, the set wins.
- Changing ITYPE does not clear ISTAT. No spurious edge is generated, because prev is independent of ITYPE.
- irq_bank[b] is registered from |(ISTAT & IEN); it lags ISTAT by one edge. irq is the combinational OR of the registered irq_bank bits.
- Reset mid-transfer aborts the transfer. The next transfer after release behaves normally.
- Back-to-back transfers (setup immediately after access) are supported with no idle cycle.

Decomposition:
- Package gpio_bank_pkg holds:
  - offset constants REG_DIR..REG_ISTAT
  - the ITYPE encoding
  - a function giving the minimum ADDR_WIDTH for BANK_NUM.
- Sub-module gpio_bank_regs holds one bank: registers, synchroniser, edge detect, ISTAT, irq_bank. It takes a bank-select strobe, write strobe, offset and pwdata, and returns its read value and pad controls.
- The top level contains:
  - the bank decode
  - the read mux and prdata/pslverr registers
  - a generate loop over BANK_NUM.

Test Plan:
- Reset, then write DIR/OUT of bank 1 = 8'hA5/8'h3C -> oe[15:8] = A5 and a[15:8] = 3C on the edge after access; reading them back returns A5/3C with pready = 1 and pslverr = 0.
- Write PU = 8'hFF and PD = 8'h0F on bank 0 -> pd[7:0] = 00 and pu[7:0] = FF; reading PD returns 0F.
- y[3] 0->1 with ITYPE = 0 and IEN = 8'h08 -> IN bit 3 = 1 after 2 edges, ISTAT = 08 after 3, irq_bank[0] = irq = 1 after 4. Write ISTAT = 08 -> irq drops 1 edge after ISTAT clears.
- y[9] 1->0 with ITYPE bit1 = 1 and IEN = 0 on bank 1 -> ISTAT = 02 and irq stays 0. A W1C issued in the same cycle as a new falling edge leaves the bit set.
- BANK_NUM = 2, access to paddr = 7'h10 (bank 2) -> pslverr = 1, prdata = 0, and no bank register changes.
- Assert preset mid-write access -> all outputs 0 at once; the next write after release completes correctly.
